// File: rtl/count_sequencer.sv
// Up/down BCD counter driven by debounced buttons, with hold-to-auto-repeat
// (initial delay, then a periodic step) and wrap at MAX_COUNT / 00.
module count_sequencer #(
    parameter int unsigned REPEAT_DELAY  = 12500000,
    parameter int unsigned REPEAT_PERIOD = 2500000,
    parameter int unsigned MAX_COUNT     = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Up,
    input  logic       i_Down,
    input  logic       i_Clear,
    output logic [3:0] o_Ones,
    output logic [3:0] o_Tens,
    output logic       o_Step,
    output logic       o_Wrap,
    output logic       o_Repeat
);

    localparam int unsigned TimerMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                       : REPEAT_PERIOD;
    localparam int unsigned TimerW   = $clog2(TimerMax);

    localparam logic [TimerW-1:0] DelayLoad  = TimerW'(REPEAT_DELAY - 1);
    localparam logic [TimerW-1:0] PeriodLoad = TimerW'(REPEAT_PERIOD - 1);
    localparam logic [TimerW-1:0] TimerOne   = TimerW'(1);
    localparam logic [3:0]        MaxTens    = 4'(MAX_COUNT / 10);
    localparam logic [3:0]        MaxOnes    = 4'(MAX_COUNT % 10);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } state_e;

    state_e              state;
    logic                dir_up;
    logic [TimerW-1:0]   timer;
    logic                prev_up;
    logic                prev_down;

    logic                rise_up;
    logic                rise_down;
    logic                held;
    logic                opposite;
    logic                abort;
    logic                do_step;
    logic                step_up;

    logic [3:0]          up_tens;
    logic [3:0]          up_ones;
    logic                up_wrap;
    logic [3:0]          dn_tens;
    logic [3:0]          dn_ones;
    logic                dn_wrap;
    logic [3:0]          step_tens;
    logic [3:0]          step_ones;
    logic                step_wrap;

    assign rise_up   = i_Up & ~prev_up;
    assign rise_down = i_Down & ~prev_down;

    // Sequence ends when the latched button drops or the other one is pressed.
    assign held     = dir_up ? i_Up : i_Down;
    assign opposite = dir_up ? i_Down : i_Up;
    assign abort    = ~held | opposite;

    always_comb begin
        up_tens = o_Tens;
        up_ones = o_Ones;
        up_wrap = 1'b0;
        if (o_Tens == MaxTens && o_Ones == MaxOnes) begin
            up_tens = 4'd0;
            up_ones = 4'd0;
            up_wrap = 1'b1;
        end else if (o_Ones == 4'd9) begin
            up_ones = 4'd0;
            up_tens = o_Tens + 4'd1;
        end else begin
            up_ones = o_Ones + 4'd1;
        end
    end

    always_comb begin
        dn_tens = o_Tens;
        dn_ones = o_Ones;
        dn_wrap = 1'b0;
        if (o_Tens == 4'd0 && o_Ones == 4'd0) begin
            dn_tens = MaxTens;
            dn_ones = MaxOnes;
            dn_wrap = 1'b1;
        end else if (o_Ones == 4'd0) begin
            dn_ones = 4'd9;
            dn_tens = o_Tens - 4'd1;
        end else begin
            dn_ones = o_Ones - 4'd1;
        end
    end

    always_comb begin
        do_step = 1'b0;
        step_up = dir_up;
        case (state)
            StIdle: begin
                if (rise_up && !i_Down) begin
                    do_step = 1'b1;
                    step_up = 1'b1;
                end else if (rise_down && !i_Up) begin
                    do_step = 1'b1;
                    step_up = 1'b0;
                end
            end
            StDelay, StRepeat: begin
                do_step = ~abort && (timer == '0);
            end
            default: do_step = 1'b0;
        endcase
    end

    always_comb begin
        step_tens = step_up ? up_tens : dn_tens;
        step_ones = step_up ? up_ones : dn_ones;
        step_wrap = step_up ? up_wrap : dn_wrap;
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= StIdle;
            dir_up    <= 1'b0;
            timer     <= '0;
            prev_up   <= 1'b0;
            prev_down <= 1'b0;
            o_Ones    <= 4'd0;
            o_Tens    <= 4'd0;
            o_Step    <= 1'b0;
            o_Wrap    <= 1'b0;
            o_Repeat  <= 1'b0;
        end else begin
            // Edge history keeps tracking through clear so a held button needs a fresh press.
            prev_up   <= i_Up;
            prev_down <= i_Down;
            if (i_Clear) begin
                state    <= StIdle;
                timer    <= '0;
                o_Ones   <= 4'd0;
                o_Tens   <= 4'd0;
                o_Step   <= 1'b0;
                o_Wrap   <= 1'b0;
                o_Repeat <= 1'b0;
            end else begin
                o_Step <= do_step;
                o_Wrap <= do_step & step_wrap;
                if (do_step) begin
                    o_Tens <= step_tens;
                    o_Ones <= step_ones;
                end
                case (state)
                    StIdle: begin
                        if (do_step) begin
                            dir_up <= step_up;
                            timer  <= DelayLoad;
                            state  <= StDelay;
                        end
                    end
                    StDelay: begin
                        if (abort) begin
                            state <= StIdle;
                            timer <= '0;
                        end else if (timer == '0) begin
                            timer    <= PeriodLoad;
                            state    <= StRepeat;
                            o_Repeat <= 1'b1;
                        end else begin
                            timer <= timer - TimerOne;
                        end
                    end
                    StRepeat: begin
                        if (abort) begin
                            state    <= StIdle;
                            timer    <= '0;
                            o_Repeat <= 1'b0;
                        end else if (timer == '0) begin
                            timer <= PeriodLoad;
                        end else begin
                            timer <= timer - TimerOne;
                        end
                    end
                    default: begin
                        state    <= StIdle;
                        timer    <= '0;
                        o_Repeat <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 12500000, meaning cycles from first step to first auto-repeat step (>=2).
REQ-002 SHALL have parameter REPEAT_PERIOD, default 2500000, meaning cycles between auto-repeat steps (>=2).
REQ-003 SHALL have parameter MAX_COUNT, default 99, meaning highest count value (1..99).
REQ-004 SHALL have port i_Clk, input, 1, the only clock; all state on its rising edge.
REQ-005 SHALL have port i_Rst_L, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_Up, input, 1, debounced increment button level.
REQ-007 SHALL have port i_Down, input, 1, debounced decrement button level.
REQ-008 SHALL have port i_Clear, input, 1, debounced clear level.
REQ-009 SHALL have port o_Ones, output, 4, BCD ones digit of count, feeding the 7-segment decoder.
REQ-010 SHALL have port o_Tens, output, 4, BCD tens digit of count.
REQ-011 SHALL have port o_Step, output, 1, one-cycle pulse on every count change.
REQ-012 SHALL have port o_Wrap, output, 1, one-cycle pulse coincident with o_Step when the count wraps.
REQ-013 SHALL have port o_Repeat, output, 1, high while in state REPEAT.

Function
REQ-014 SHALL register i_Up and i_Down into previous-level flops; rise = level AND NOT previous, evaluated combinationally each edge.
REQ-015 SHALL implement FSM states IDLE, DELAY, REPEAT plus a latched direction bit and a down-counting timer sized for max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-016 IDLE: on an edge with exactly one of rise(Up)/rise(Down) and the other input low, SHALL step once in that direction, latch direction, load timer REPEAT_DELAY-1, enter DELAY.
REQ-017 IDLE: rises of both inputs on the same edge SHALL produce no step and remain in IDLE.
REQ-018 DELAY: timer SHALL decrement each edge; on an edge with timer==0 SHALL step, load REPEAT_PERIOD-1, enter REPEAT.
REQ-019 REPEAT: timer SHALL decrement each edge; on timer==0 SHALL step and reload REPEAT_PERIOD-1.
REQ-020 In DELAY or REPEAT, if the latched button is low or the opposite button is high, SHALL enter IDLE with no step on that edge, taking priority over timer expiry.
REQ-021 The count update SHALL be visible on the outputs immediately after the stepping edge; o_Step is high for exactly that following cycle.
REQ-022 Up step SHALL be BCD: ones 9->0 with tens+1; if count==MAX_COUNT, SHALL go to 00 and pulse o_Wrap.
REQ-023 Down step SHALL be BCD: ones 0->9 with tens-1; if count==00, SHALL go to MAX_COUNT and pulse o_Wrap.
REQ-024 o_Tens SHALL never exceed 9 and the count SHALL never exceed MAX_COUNT.
REQ-025 i_Clear high on any edge SHALL force count 00, state IDLE, timer 0, o_Step=0, o_Wrap=0, overriding all other inputs; button previous-level flops still update.
REQ-026 After clear is released while a button stays held, no step SHALL occur until that button produces a new rise.

Reset
REQ-027 On i_Rst_L low, SHALL immediately force o_Ones=0, o_Tens=0, o_Step=0, o_Wrap=0, o_Repeat=0, state IDLE, timer 0, previous-level flops 0.
REQ-028 A button held high through reset release SHALL register one rise on the first edge after release.
REQ-029 Reset asserted mid-DELAY or mid-REPEAT SHALL abort the sequence with no further step.

Verification (REPEAT_DELAY=4, REPEAT_PERIOD=2, MAX_COUNT=12)
REQ-030 From 00, single Up press held 1 edge then released -> count 01, one o_Step pulse, o_Repeat stays 0.
REQ-031 From 00, Up held for 9 edges (step edge = edge 0) -> steps at edges 0,4,6,8, count 04, o_Repeat high from edge 4.
REQ-032 From 12, Up rise -> count 00 with o_Step and o_Wrap; from 00, Down rise -> count 12 with o_Wrap.
REQ-033 From 09, Up rise -> o_Tens=1, o_Ones=0; Down rise -> back to 09.
REQ-034 Up and Down rise on same edge -> no step; during REPEAT, Down asserted -> IDLE, no step, o_Repeat=0.
REQ-035 i_Clear during REPEAT at count 07 -> 00 next edge, no o_Step; i_Rst_L low mid-DELAY -> all outputs 0 asynchronously.
